// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the fetch sequencer.
// State encoding, fault codes and the default reset PC.
package fetch_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    FAULT = 2'd3
  } fseq_state_t;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ALIGN   = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/fetch_timer.sv
// Fetch wait counter: clr/en control, expired on the LIMIT-th waiting cycle.
// Ports: clk, rst (sync, active-high), clr, en, expired.
module fetch_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt;

  // cnt counts completed ack-less cycles, so the current
  // cycle is the LIMIT-th one when cnt == LIMIT-1.
  assign expired = (cnt == 8'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 8'd1;
  end

endmodule

// File: rtl/fetch_seq.sv
// Multi-cycle fetch sequencer: owns the PC, fetches, issues, retires.
// Ports: clk/rst, run, imem req/addr/ack/rdata, pc/npc_in, inst, exec_done, fault info, retire_cnt.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  input  logic [31:0] npc_in,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        exec_done,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] fault_pc,
  output logic [31:0] retire_cnt
);

  fseq_state_t state;
  logic        tmr_clr;
  logic        tmr_en;
  logic        expired;

  assign imem_addr = pc;
  assign tmr_en    = (state == FETCH) && !imem_ack;
  assign tmr_clr   = (state != FETCH) || imem_ack;

  fetch_timer #(
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      inst       <= '0;
      inst_valid <= 1'b0;
      imem_req   <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
      fault_pc   <= '0;
      retire_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (run) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        FETCH: begin
          // ack on the last allowed cycle still wins
          if (imem_ack) begin
            inst       <= imem_rdata;
            inst_valid <= 1'b1;
            imem_req   <= 1'b0;
            state      <= ISSUE;
          end else if (expired) begin
            fault      <= 1'b1;
            fault_code <= FC_TIMEOUT;
            fault_pc   <= pc;
            imem_req   <= 1'b0;
            state      <= FAULT;
          end
        end
        ISSUE: begin
          if (exec_done) begin
            inst_valid <= 1'b0;
            if (npc_in[1:0] == 2'b00) begin
              pc         <= npc_in;
              retire_cnt <= retire_cnt + 32'd1;
              if (run) begin
                state    <= FETCH;
                imem_req <= 1'b1;
              end else begin
                state    <= IDLE;
              end
            end else begin
              fault      <= 1'b1;
              fault_code <= FC_ALIGN;
              fault_pc   <= pc;
              state      <= FAULT;
            end
          end
        end
        FAULT: begin
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
        default: state <= FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed-vector bench for fetch_seq.
// Drives and samples 1ns after each rising edge.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] npc_in;
  logic [31:0] inst;
  logic        inst_valid;
  logic        exec_done;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] fault_pc;
  logic [31:0] retire_cnt;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  fetch_seq #(
    .RESET_PC (32'h0000_3000),
    .TIMEOUT  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .npc_in     (npc_in),
    .inst       (inst),
    .inst_valid (inst_valid),
    .exec_done  (exec_done),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_pc   (fault_pc),
    .retire_cnt (retire_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // wait lat cycles in FETCH, then one-cycle ack
  task automatic fetch(input logic [31:0] data, input int lat);
    repeat (lat) step();
    imem_ack   = 1'b1;
    imem_rdata = data;
    step();
    imem_ack   = 1'b0;
  endtask

  // hold exec_done low for hold cycles, then pulse it
  task automatic retire(input logic [31:0] npc, input int hold);
    npc_in = npc;
    repeat (hold) step();
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".pc"},    pc,         32'h0000_3000);
    chk({tag, ".req"},   32'(imem_req), 32'd0);
    chk({tag, ".flt"},   32'(fault), 32'd0);
    chk({tag, ".fcode"}, 32'(fault_code), 32'd0);
    chk({tag, ".fpc"},   fault_pc,   32'd0);
    chk({tag, ".ret"},   retire_cnt, 32'd0);
    chk({tag, ".ival"},  32'(inst_valid), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    run        = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    npc_in     = '0;
    exec_done  = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk_reset("rst");
    chk("rst.inst", inst, 32'd0);

    // run low: stays idle, stray ack ignored
    imem_ack = 1'b1;
    imem_rdata = 32'hdead_beef;
    step();
    imem_ack = 1'b0;
    step();
    chk("idle.req", 32'(imem_req), 32'd0);
    chk("idle.ival", 32'(inst_valid), 32'd0);

    // T1: single instruction
    run = 1'b1;
    step();
    chk("t1.req", 32'(imem_req), 32'd1);
    chk("t1.addr", imem_addr, 32'h0000_3000);
    fetch(32'h2408_0005, 2);
    chk("t1.ival", 32'(inst_valid), 32'd1);
    chk("t1.inst", inst, 32'h2408_0005);
    chk("t1.req0", 32'(imem_req), 32'd0);
    retire(32'h0000_3004, 1);
    chk("t1.pc", pc, 32'h0000_3004);
    chk("t1.ret", retire_cnt, 32'd1);
    chk("t1.ival0", 32'(inst_valid), 32'd0);
    chk("t1.req2", 32'(imem_req), 32'd1);
    chk("t1.addr2", imem_addr, 32'h0000_3004);

    // T2: hold inst, jump, third fetch
    fetch(32'h1111_2222, 0);
    for (int i = 0; i < 5; i++) begin
      imem_rdata = 32'h5555_0000 + 32'(i);
      chk("t2.hold", inst, 32'h1111_2222);
      step();
    end
    chk("t2.hival", 32'(inst_valid), 32'd1);
    retire(32'h0000_3040, 0);
    chk("t2.addr", imem_addr, 32'h0000_3040);
    chk("t2.req", 32'(imem_req), 32'd1);
    fetch(32'h3333_4444, 1);
    chk("t2.inst3", inst, 32'h3333_4444);
    retire(32'h0000_3044, 0);
    chk("t2.ret", retire_cnt, 32'd3);
    chk("t2.pc", pc, 32'h0000_3044);

    // T6: run dropped during ISSUE
    fetch(32'h0000_0013, 0);
    run = 1'b0;
    retire(32'h0000_3048, 2);
    chk("t6.pc", pc, 32'h0000_3048);
    chk("t6.ret", retire_cnt, 32'd4);
    chk("t6.req", 32'(imem_req), 32'd0);
    repeat (3) step();
    chk("t6.req3", 32'(imem_req), 32'd0);
    chk("t6.ival", 32'(inst_valid), 32'd0);
    run = 1'b1;
    step();
    chk("t6.resume", 32'(imem_req), 32'd1);
    chk("t6.addr", imem_addr, 32'h0000_3048);

    // T4b: ack on the 16th FETCH cycle is accepted
    fetch(32'hcafe_f00d, 15);
    chk("t4b.ival", 32'(inst_valid), 32'd1);
    chk("t4b.flt", 32'(fault), 32'd0);
    chk("t4b.inst", inst, 32'hcafe_f00d);
    retire(32'h0000_304c, 0);
    chk("t4b.pc", pc, 32'h0000_304c);

    // T4a: no ack for 16 cycles -> timeout
    repeat (15) step();
    chk("t4a.pre", 32'(fault), 32'd0);
    chk("t4a.preq", 32'(imem_req), 32'd1);
    step();
    chk("t4a.flt", 32'(fault), 32'd1);
    chk("t4a.code", 32'(fault_code), 32'd2);
    chk("t4a.fpc", fault_pc, 32'h0000_304c);
    chk("t4a.req", 32'(imem_req), 32'd0);
    chk("t4a.ret", retire_cnt, 32'd5);

    // T5: reset from FAULT, then reset mid-FETCH
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("t5f");
    step();
    chk("t5.req", 32'(imem_req), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("t5r");

    // T3: misaligned next PC
    step();
    fetch(32'h0040_0093, 0);
    retire(32'h0000_3006, 1);
    chk("t3.flt", 32'(fault), 32'd1);
    chk("t3.code", 32'(fault_code), 32'd1);
    chk("t3.fpc", fault_pc, 32'h0000_3000);
    chk("t3.pc", pc, 32'h0000_3000);
    chk("t3.ret", retire_cnt, 32'd0);
    chk("t3.ival", 32'(inst_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      imem_ack = (i == 4);
      exec_done = (i == 6);
      npc_in = 32'h0000_3100;
      chk("t3.req", 32'(imem_req), 32'd0);
      step();
    end
    imem_ack = 1'b0;
    exec_done = 1'b0;
    chk("t3.pcf", pc, 32'h0000_3000);
    chk("t3.codef", 32'(fault_code), 32'd1);
    chk("t3.fpcf", fault_pc, 32'h0000_3000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
